// File: rtl/test_bcd_to_7seg_8displays_pkg.sv
// Shared constants for the eight-digit BCD display test wrapper.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package test_bcd_to_7seg_8displays_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0      = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1      = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2      = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3      = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4      = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5      = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6      = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7      = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8      = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9      = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK  = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_ALL_ON = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Single-digit BCD to active-low 7-segment decoder, purely combinational.
// Codes 10-15 are not valid BCD and show a blank display.
module bcd_to_7seg
    import test_bcd_to_7seg_8displays_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/test_bcd_to_7seg_8displays.sv
// Eight-digit free-running BCD counter driving eight registered active-low
// 7-segment displays, advanced by a prescaled tick, with a lamp-test override.
module test_bcd_to_7seg_8displays
    import test_bcd_to_7seg_8displays_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       seg7all_on,
    output logic [6:0] sg7_hex0,
    output logic [6:0] sg7_hex1,
    output logic [6:0] sg7_hex2,
    output logic [6:0] sg7_hex3,
    output logic [6:0] sg7_hex4,
    output logic [6:0] sg7_hex5,
    output logic [6:0] sg7_hex6,
    output logic [6:0] sg7_hex7
);

    localparam int PS_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_CYCLES - 1);

    logic [PS_W-1:0]                   presc_q, presc_d;
    logic                              tick;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]  digits_q, digits_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]  dec_seg;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]  seg_q, seg_d;
    logic                              carry;

    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (enable) begin
            if (presc_q == PS_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Ripple carry resolves through all digits within the tick cycle.
    always_comb begin
        digits_d = digits_q;
        carry    = tick;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (digits_q[i] >= 4'd9) begin
                    digits_d[i] = '0;
                end else begin
                    digits_d[i] = digits_q[i] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        bcd_to_7seg u_dec (
            .digit (digits_q[g]),
            .seg   (dec_seg[g])
        );
    end

    always_comb begin
        seg_d = dec_seg;
        if (seg7all_on)
            seg_d = {NUM_DIGITS{SEG_ALL_ON}};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q  <= '0;
            digits_q <= '0;
            seg_q    <= {NUM_DIGITS{SEG_0}};
        end else begin
            presc_q  <= presc_d;
            digits_q <= digits_d;
            seg_q    <= seg_d;
        end
    end

    assign sg7_hex0 = seg_q[0];
    assign sg7_hex1 = seg_q[1];
    assign sg7_hex2 = seg_q[2];
    assign sg7_hex3 = seg_q[3];
    assign sg7_hex4 = seg_q[4];
    assign sg7_hex5 = seg_q[5];
    assign sg7_hex6 = seg_q[6];
    assign sg7_hex7 = seg_q[7];

endmodule

// File: tb/tb_test_bcd_to_7seg_8displays.sv
// Directed bench for the eight-digit BCD display wrapper with a short prescaler.
module tb_test_bcd_to_7seg_8displays;

    localparam int TICK = 4;

    logic clock, reset_n, enable, seg7all_on;
    logic [6:0] h0, h1, h2, h3, h4, h5, h6, h7;
    logic [7:0][6:0] hex;

    int tests = 0;
    int fails = 0;

    test_bcd_to_7seg_8displays #(.TICK_CYCLES(TICK), .NUM_DIGITS(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .seg7all_on (seg7all_on),
        .sg7_hex0   (h0),
        .sg7_hex1   (h1),
        .sg7_hex2   (h2),
        .sg7_hex3   (h3),
        .sg7_hex4   (h4),
        .sg7_hex5   (h5),
        .sg7_hex6   (h6),
        .sg7_hex7   (h7)
    );

    assign hex = {h7, h6, h5, h4, h3, h2, h1, h0};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string           name;
        logic            en;
        logic            lamp;
        int              n;
        logic [7:0][6:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0][6:0] segs_of(input int value);
        logic [6:0] tab [10];
        logic [7:0][6:0] r;
        int v;
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        v = value;
        for (int d = 0; d < 8; d++) begin
            r[d] = tab[v % 10];
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0][6:0] fill(input logic [6:0] s);
        return {8{s}};
    endfunction

    task automatic check(input string name, input logic [7:0][6:0] exp);
        for (int d = 0; d < 8; d++) begin
            tests++;
            if (hex[d] !== exp[d]) begin
                fails++;
                $display("FAIL %s hex%0d: got %h, expected %h", name, d, hex[d], exp[d]);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    function automatic vec_t mk(input string nm, input logic e, input logic l,
                                input int n, input logic [7:0][6:0] x);
        vec_t v;
        v.name = nm; v.en = e; v.lamp = l; v.n = n; v.exp = x;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk("lamp_on",       1'b0, 1'b1,   1, fill(7'h00)));
        vecs.push_back(mk("lamp_off",      1'b0, 1'b0,   1, segs_of(0)));
        vecs.push_back(mk("first_tick",    1'b1, 1'b0,   4, segs_of(0)));
        vecs.push_back(mk("show_1",        1'b1, 1'b0,   1, segs_of(1)));
        vecs.push_back(mk("run_to_4",      1'b1, 1'b0,  14, segs_of(4)));
        vecs.push_back(mk("tick_5_hidden", 1'b1, 1'b0,   1, segs_of(4)));
        vecs.push_back(mk("show_5",        1'b1, 1'b0,   1, segs_of(5)));
        vecs.push_back(mk("hold_20",       1'b0, 1'b0,  20, segs_of(5)));
        vecs.push_back(mk("resume_2",      1'b1, 1'b0,   2, segs_of(5)));
        vecs.push_back(mk("resume_tick",   1'b1, 1'b0,   1, segs_of(5)));
        vecs.push_back(mk("show_6",        1'b1, 1'b0,   1, segs_of(6)));
        vecs.push_back(mk("show_9",        1'b1, 1'b0,  12, segs_of(9)));
        vecs.push_back(mk("carry_10",      1'b1, 1'b0,   4, segs_of(10)));
        vecs.push_back(mk("lamp_running",  1'b1, 1'b1,   1, fill(7'h00)));
        vecs.push_back(mk("lamp_release",  1'b1, 1'b0,   1, segs_of(10)));
        vecs.push_back(mk("tick_11",       1'b1, 1'b0,   1, segs_of(10)));
        vecs.push_back(mk("show_11",       1'b1, 1'b0,   1, segs_of(11)));
        vecs.push_back(mk("run_to_37",     1'b1, 1'b0, 104, segs_of(37)));

        reset_n    = 1'b0;
        enable     = 1'b1;
        seg7all_on = 1'b0;
        run(3);
        check("reset_hold", segs_of(0));
        reset_n = 1'b1;
        enable  = 1'b0;

        foreach (vecs[k]) begin
            enable     = vecs[k].en;
            seg7all_on = vecs[k].lamp;
            run(vecs[k].n);
            check(vecs[k].name, vecs[k].exp);
        end

        // Asynchronous reset between edges at count 37.
        #2 reset_n = 1'b0;
        #1 check("async_reset", segs_of(0));
        @(negedge clock);
        reset_n = 1'b1;
        enable  = 1'b1;
        run(4);
        check("restart_latency", segs_of(0));
        run(1);
        check("restart_1", segs_of(1));

        // Preload 99999999 with the counter frozen, then let one tick wrap it.
        enable = 1'b0;
        force dut.digits_q = 32'h9999_9999;
        @(posedge clock);
        @(negedge clock);
        release dut.digits_q;
        run(1);
        check("preload_9s", segs_of(99999999));
        enable = 1'b1;
        run(2);
        check("pre_wrap", segs_of(99999999));
        run(1);
        check("wrap_tick", segs_of(99999999));
        run(1);
        check("wrap_zero", segs_of(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
